// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 add/sub datapath.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int GRS_W = 3;
  localparam int EXT_W = MAN_W + 1 + GRS_W;  // {hidden, frac, G, R, S} = 27
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  // Contents of the align-stage pipeline register.
  typedef struct packed {
    logic             op;         // 1: effective addition
    logic [EXP_W-1:0] exp_l;
    logic             sign_l;
    logic [EXT_W-1:0] mant_l;
    logic [EXT_W-1:0] aligned_s;
    logic             exc;
  } align_stage_t;

  // Extended mantissa; zero-exponent operands (zeros and subnormals) flush to 0.
  function automatic logic [EXT_W-1:0] ext_mant(input fp32_t x);
    return (x.exp != '0) ? {1'b1, x.frac, {GRS_W{1'b0}}} : '0;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Right shift of a 27-bit extended mantissa with sticky collapse into bit 0.
// Shift amounts of 27 or more collapse the whole operand into the sticky bit.
module fp_align_shifter
  import fp_pkg::*;
(
  input  logic [EXT_W-1:0] mant_in,
  input  logic [EXP_W-1:0] shamt,
  output logic [EXT_W-1:0] mant_out
);

  logic [EXT_W-1:0] lost_mask;
  logic [EXT_W-1:0] shifted;
  logic             lost;
  logic             saturate;

  // Bit gi falls off the bottom when the shift amount exceeds gi.
  generate
    for (genvar gi = 0; gi < EXT_W; gi++) begin : g_mask
      assign lost_mask[gi] = (shamt > EXP_W'(gi));
    end
  endgenerate

  assign shifted  = mant_in >> shamt;
  assign lost     = |(mant_in & lost_mask);
  assign saturate = (shamt >= EXP_W'(EXT_W));

  // Select saturated sticky-only result or shifted value with sticky OR-ed in.
  always_comb begin
    mant_out = '0;
    if (saturate) begin
      mant_out = {{(EXT_W-1){1'b0}}, |mant_in};
    end else begin
      mant_out = {shifted[EXT_W-1:1], shifted[0] | lost};
    end
  end

endmodule

// File: rtl/fp_align_addsub.sv
// FP32 add/sub front half: unpack, swap, align, add/subtract extended mantissas.
// Two-stage valid/ready pipeline; normalization and rounding happen downstream.
module fp_align_addsub
  import fp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAN_W+3:0]   result_mant,
  output logic               carry_out,
  output logic               op,
  output logic [EXP_W-1:0]   exp_result,
  output logic               result_sign,
  output logic               exc
);

  localparam int XW = MAN_W + 4;

  fp32_t            fa, fb;
  logic             sb_eff;
  logic             swap;
  logic [EXP_W-1:0] exp_s;
  logic [XW-1:0]    mant_s;
  logic [EXP_W-1:0] shamt;
  align_stage_t     s1_next, s1_reg;
  logic             v1_reg, v2_reg;
  logic             acc1, acc2;
  logic [XW:0]      sum_next;
  logic             sign_next;

  assign fa = a;
  assign fb = b;

  // Handshake: a stage may load when empty or when the stage after it drains.
  assign acc2      = !v2_reg || out_ready;
  assign acc1      = !v1_reg || acc2;
  assign in_ready  = acc1;
  assign out_valid = v2_reg;

  // Stage 1 operand selection: larger magnitude leads, ties keep A in front.
  always_comb begin
    sb_eff            = fb.sign ^ sub;
    swap              = {fb.exp, fb.frac} > {fa.exp, fa.frac};
    s1_next.op        = ~(fa.sign ^ sb_eff);
    s1_next.exc       = (fa.exp == EXP_MAX) || (fb.exp == EXP_MAX);
    s1_next.exp_l     = swap ? fb.exp : fa.exp;
    s1_next.sign_l    = swap ? sb_eff : fa.sign;
    s1_next.mant_l    = swap ? ext_mant(fb) : ext_mant(fa);
    exp_s             = swap ? fa.exp : fb.exp;
    mant_s            = swap ? ext_mant(fa) : ext_mant(fb);
    shamt             = s1_next.exp_l - exp_s;
  end

  fp_align_shifter u_shifter (
    .mant_in  (mant_s),
    .shamt    (shamt),
    .mant_out (s1_next.aligned_s)
  );

  // Stage 2 adder; the swap keeps the difference non-negative so bit 27 is 0 on subtract.
  always_comb begin
    if (s1_reg.op) begin
      sum_next = {1'b0, s1_reg.mant_l} + {1'b0, s1_reg.aligned_s};
    end else begin
      sum_next = {1'b0, s1_reg.mant_l} - {1'b0, s1_reg.aligned_s};
    end
    sign_next = s1_reg.sign_l;
    if (!s1_reg.op && (sum_next[XW-1:0] == '0)) begin
      sign_next = 1'b0;
    end
  end

  // Stage 1 register: captures aligned operands on an accepted input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_reg <= 1'b0;
      s1_reg <= '0;
    end else if (acc1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        s1_reg <= s1_next;
      end
    end
  end

  // Stage 2 register: holds the result until downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_reg      <= 1'b0;
      result_mant <= '0;
      carry_out   <= 1'b0;
      op          <= 1'b0;
      exp_result  <= '0;
      result_sign <= 1'b0;
      exc         <= 1'b0;
    end else if (acc2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        result_mant <= sum_next[XW-1:0];
        carry_out   <= sum_next[XW];
        op          <= s1_reg.op;
        exp_result  <= s1_reg.exp_l;
        result_sign <= sign_next;
        exc         <= s1_reg.exc;
      end
    end
  end

endmodule
